// File: rtl/carregador_instrucoes_pkg.sv
// Shared definitions for the instruction loader.
// Holds the default word/address widths and the loader state type.
package carregador_instrucoes_pkg;
  localparam int LARGURA_DADO_PADRAO = 8;
  localparam int LARGURA_END_PADRAO  = 8;

  typedef enum logic [1:0] {
    OCIOSO,
    RECEBENDO,
    ESCREVENDO,
    CONCLUIDO
  } estado_t;
endpackage

// File: rtl/contador_endereco.sv
// Write-address counter for the instruction loader.
// Ports:
//   clk, reset       - clock and synchronous active-high reset (reset -> VALOR_RESET)
//   carregar         - load valor_carga (takes priority over incrementar)
//   valor_carga      - value loaded on carregar
//   incrementar      - advance the address by one
//   endereco         - current address
//   terminal         - high when endereco is the last address of the space
module contador_endereco #(
  parameter int                 LARGURA     = 8,
  parameter logic [LARGURA-1:0] VALOR_RESET = '0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               carregar,
  input  logic [LARGURA-1:0] valor_carga,
  input  logic               incrementar,
  output logic [LARGURA-1:0] endereco,
  output logic               terminal
);
  always_ff @(posedge clk) begin
    if (reset)            endereco <= VALOR_RESET;
    else if (carregar)    endereco <= valor_carga;
    else if (incrementar) endereco <= endereco + 1'b1;
  end

  assign terminal = &endereco;
endmodule

// File: rtl/carregador_instrucoes.sv
// Program loader: accepts a stream of instruction words through a
// valid/ready handshake and writes them to consecutive addresses of an
// instruction memory, one word every two cycles.
// Ports:
//   clk, reset          - clock and synchronous active-high reset
//   iniciar             - pulse that starts a load (only in OCIOSO/CONCLUIDO)
//   dado, valido, ultimo- source word, its valid flag, final-word marker
//   pronto              - loader accepts dado this cycle
//   mem_we, mem_endereco, mem_dado - instruction memory write port
//   ocupado, concluido  - load in progress / load finished
//   erro                - address space exhausted before the final word
//   quantidade          - words written in the current/last load
module carregador_instrucoes
  import carregador_instrucoes_pkg::*;
#(
  parameter int                     LARGURA_DADO = LARGURA_DADO_PADRAO,
  parameter int                     LARGURA_END  = LARGURA_END_PADRAO,
  parameter logic [LARGURA_END-1:0] END_INICIAL  = '0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    iniciar,
  input  logic [LARGURA_DADO-1:0] dado,
  input  logic                    valido,
  input  logic                    ultimo,
  output logic                    pronto,
  output logic                    mem_we,
  output logic [LARGURA_END-1:0]  mem_endereco,
  output logic [LARGURA_DADO-1:0] mem_dado,
  output logic                    ocupado,
  output logic                    concluido,
  output logic                    erro,
  output logic [LARGURA_END:0]    quantidade
);
  estado_t estado, prox;
  logic    ultimo_reg;
  logic    carregar, incrementar, terminal, estouro, aceita;

  contador_endereco #(
    .LARGURA     (LARGURA_END),
    .VALOR_RESET (END_INICIAL)
  ) u_contador (
    .clk         (clk),
    .reset       (reset),
    .carregar    (carregar),
    .valor_carga (END_INICIAL),
    .incrementar (incrementar),
    .endereco    (mem_endereco),
    .terminal    (terminal)
  );

  assign aceita = (estado == RECEBENDO) && valido;

  always_comb begin
    prox        = estado;
    carregar    = 1'b0;
    incrementar = 1'b0;
    estouro     = 1'b0;
    case (estado)
      OCIOSO, CONCLUIDO: begin
        if (iniciar) begin
          prox     = RECEBENDO;
          carregar = 1'b1;
        end
      end
      RECEBENDO: begin
        if (valido) prox = ESCREVENDO;
      end
      ESCREVENDO: begin
        if (ultimo_reg) begin
          prox = CONCLUIDO;
        end else if (terminal) begin
          // Last address written without the final marker: stop instead of
          // wrapping back onto the start of the program.
          prox    = CONCLUIDO;
          estouro = 1'b1;
        end else begin
          prox        = RECEBENDO;
          incrementar = 1'b1;
        end
      end
      default: prox = OCIOSO;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      estado     <= OCIOSO;
      mem_dado   <= '0;
      ultimo_reg <= 1'b0;
      quantidade <= '0;
      erro       <= 1'b0;
    end else begin
      estado <= prox;
      if (carregar) begin
        quantidade <= '0;
        erro       <= 1'b0;
      end
      if (aceita) begin
        mem_dado   <= dado;
        ultimo_reg <= ultimo;
      end
      if (estado == ESCREVENDO) quantidade <= quantidade + 1'b1;
      if (estouro)              erro       <= 1'b1;
    end
  end

  // Gating with reset aborts a write whose cycle coincides with reset, so
  // memory never sees a word the loader is about to forget.
  assign pronto    = (estado == RECEBENDO)  && !reset;
  assign mem_we    = (estado == ESCREVENDO) && !reset;
  assign ocupado   = (estado == RECEBENDO) || (estado == ESCREVENDO);
  assign concluido = (estado == CONCLUIDO);
endmodule

// File: tb/tb_carregador_instrucoes.sv
module tb_carregador_instrucoes;
  logic       clk = 1'b0;
  logic       reset, iniciar, valido, ultimo;
  logic [7:0] dado;
  logic       pronto, mem_we, ocupado, concluido, erro;
  logic [7:0] mem_endereco, mem_dado;
  logic [8:0] quantidade;

  carregador_instrucoes dut (
    .clk(clk), .reset(reset), .iniciar(iniciar), .dado(dado), .valido(valido),
    .ultimo(ultimo), .pronto(pronto), .mem_we(mem_we), .mem_endereco(mem_endereco),
    .mem_dado(mem_dado), .ocupado(ocupado), .concluido(concluido), .erro(erro),
    .quantidade(quantidade)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Instruction memory model fed by the write port; read back after loads.
  logic [7:0] tb_mem [256];
  always @(posedge clk) if (mem_we) tb_mem[mem_endereco] <= mem_dado;

  // Behavioural model: words accepted so far in this load, load state.
  typedef struct { logic [7:0] a; logic [7:0] d; int c; } wr_t;
  wr_t exp_q[$];
  int  m_idx    = 0;
  bit  m_active = 0;
  bit  m_done   = 0;
  bit  m_err    = 0;

  task automatic chk(input string nome, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nome, got, want, $time);
    end
  endtask

  // Per-cycle compare against the model.
  always @(negedge clk) begin
    if (!reset) begin
      if (mem_we) begin
        if (exp_q.size() == 0) chk("unexpected_we", {24'd0, mem_endereco}, 32'hFFFF);
        else begin
          wr_t e;
          e = exp_q.pop_front();
          chk("wr_addr", {24'd0, mem_endereco}, {24'd0, e.a});
          chk("wr_data", {24'd0, mem_dado}, {24'd0, e.d});
          chk("wr_latency", cyc, e.c);
        end
      end else begin
        if (exp_q.size() > 0 && exp_q[0].c < cyc) begin
          chk("missed_we", 0, 1);
          void'(exp_q.pop_front());
        end
        chk("quantidade", {23'd0, quantidade}, m_idx);
        chk("erro", erro, m_err);
        chk("concluido", concluido, m_done);
        chk("ocupado", ocupado, m_active);
        chk("pronto", pronto, m_active);
      end
    end
  end

  task automatic start();
    @(negedge clk); iniciar = 1'b1;
    @(posedge clk); #1; iniciar = 1'b0;
    if (!m_active) begin
      m_active = 1; m_done = 0; m_err = 0; m_idx = 0;
    end
  endtask

  task automatic send_word(input logic [7:0] d, input logic u, input int gap, input bit push);
    int t;
    if (gap > 0) begin
      @(negedge clk);  // write cycle of the previous word
      for (int g = 0; g < gap; g++) begin
        @(negedge clk); valido = 1'b0;
        chk("gap_pronto", pronto, 1);
        chk("gap_we", mem_we, 0);
      end
    end
    @(negedge clk); valido = 1'b1; dado = d; ultimo = u; t = 0;
    while (!pronto && t < 50) begin @(negedge clk); t++; end
    if (!pronto) begin
      chk("pronto_timeout", pronto, 1);
      valido = 1'b0;
      return;
    end
    @(posedge clk); #1; valido = 1'b0; ultimo = 1'b0;
    if (push) begin
      exp_q.push_back('{a: 8'(m_idx), d: d, c: cyc});
      m_idx++;
      if (u) begin m_active = 0; m_done = 1; end
      else if (m_idx == 256) begin m_active = 0; m_done = 1; m_err = 1; end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; iniciar = 1'b0; valido = 1'b0; ultimo = 1'b0; dado = 8'h00;
    for (int i = 0; i < 256; i++) tb_mem[i] = 8'h00;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_pronto", pronto, 0);
    chk("rst_we", mem_we, 0);
    chk("rst_addr", {24'd0, mem_endereco}, 0);
    chk("rst_data", {24'd0, mem_dado}, 0);
    chk("rst_qtd", {23'd0, quantidade}, 0);

    // Basic three-word load.
    start();
    send_word(8'h12, 1'b0, 0, 1);
    send_word(8'h34, 1'b0, 0, 1);
    send_word(8'hA5, 1'b1, 0, 1);
    idle(3);
    chk("lit_mem0", {24'd0, tb_mem[0]}, 32'h12);
    chk("lit_mem1", {24'd0, tb_mem[1]}, 32'h34);
    chk("lit_mem2", {24'd0, tb_mem[2]}, 32'hA5);
    chk("lit_qtd3", {23'd0, quantidade}, 3);
    chk("lit_conc", concluido, 1);
    chk("lit_erro0", erro, 0);

    // Restart from CONCLUIDO; iniciar during RECEBENDO is ignored.
    start();
    chk("restart_qtd", {23'd0, quantidade}, 0);
    chk("restart_conc", concluido, 0);
    chk("restart_addr", {24'd0, mem_endereco}, 0);
    send_word(8'h55, 1'b0, 0, 1);
    idle(2);
    start();
    send_word(8'h66, 1'b0, 0, 1);
    send_word(8'h77, 1'b1, 0, 1);
    idle(3);
    chk("lit_ign_mem1", {24'd0, tb_mem[1]}, 32'h66);
    chk("lit_ign_qtd", {23'd0, quantidade}, 3);

    // Same program as the first load, with 4-cycle gaps between words.
    start();
    send_word(8'h12, 1'b0, 0, 1);
    send_word(8'h34, 1'b0, 4, 1);
    send_word(8'hA5, 1'b1, 4, 1);
    idle(3);
    chk("gap_mem0", {24'd0, tb_mem[0]}, 32'h12);
    chk("gap_mem1", {24'd0, tb_mem[1]}, 32'h34);
    chk("gap_mem2", {24'd0, tb_mem[2]}, 32'hA5);

    // Reset during the write cycle of word 2.
    start();
    send_word(8'h9A, 1'b0, 0, 1);
    send_word(8'hBC, 1'b0, 0, 0);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_we", mem_we, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    m_active = 0; m_done = 0; m_err = 0; m_idx = 0;
    @(negedge clk);
    chk("abort_ocupado", ocupado, 0);
    chk("abort_addr", {24'd0, mem_endereco}, 0);
    chk("abort_data", {24'd0, mem_dado}, 0);
    chk("abort_qtd", {23'd0, quantidade}, 0);
    chk("abort_mem1", {24'd0, tb_mem[1]}, 32'h34);

    // Fill the whole address space without a final marker.
    start();
    for (int i = 0; i < 256; i++) send_word(8'(i) ^ 8'h3C, 1'b0, 0, 1);
    idle(3);
    chk("ovf_erro", erro, 1);
    chk("ovf_conc", concluido, 1);
    chk("ovf_qtd", {23'd0, quantidade}, 256);
    chk("ovf_mem_ff", {24'd0, tb_mem[255]}, 32'hC3);
    chk("ovf_mem_00", {24'd0, tb_mem[0]}, 32'h3C);
    @(negedge clk); valido = 1'b1; dado = 8'hEE;
    repeat (5) begin @(negedge clk); chk("ovf_no_accept", pronto, 0); end
    valido = 1'b0;
    chk("ovf_mem_00_kept", {24'd0, tb_mem[0]}, 32'h3C);
    chk("queue_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
